pga_responder: RTL
==================

Name: pga_responder

Overview:
- Device-side end of the PGA gain-setting serial link. It is the responder that receives the 8-bit gain code the PGA interface shifts out MSB-first with cs_n low.
- It is used as a bench/behavioural PGA model and as an on-FPGA loopback target.
- It deserialises each frame, checks framing, clamps the code to the legal range, and holds the committed gain with update and error strobes.
- It is clocked by the same serial clock as the initiator. The initiator drives data and cs_n on falling sck; this block samples on rising sck.

Parameters:
- WIDTH, 8, bits per frame and width of the gain code.
- MAX_CODE, 8'hFF, highest legal gain code. Larger received codes are clamped to this value.
- ERR_CNT_W, 8, width of the saturating framing-error counter.

Ports:
- sck  input  1  serial clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- cs_n  input  1  active-low frame select from the initiator.
- sdi  input  1  serial data from the initiator, MSB first.
- gain_o  output  WIDTH  last committed (clamped) gain code.
- gain_valid_o  output  1  high once at least one good frame has been committed.
- update_o  output  1  one-cycle pulse on each commit.
- clamp_o  output  1  one-cycle pulse, coincident with update_o, when the received code > MAX_CODE.
- frame_err_o  output  1  one-cycle pulse when a frame ends with bit count != WIDTH.
- err_count_o  output  ERR_CNT_W  saturating count of framing errors.
- busy_o  output  1  high while a frame is being received (state RX).

Behaviour:
- Reset (asynchronous, any time including mid-frame): all outputs are 0, shift register 0, bit count 0, state IDLE.
- After reset, a frame already in progress is received partially. It ends as a framing error and no commit occurs.
- States: IDLE, RX, DONE.
- IDLE: on a rising sck with cs_n=0, sample sdi into the shift register LSB (shifting left), set bit count to 1, go to RX. Otherwise stay in IDLE.
- RX, cs_n=0, count < WIDTH: shift sdi in and increment count.
- RX, cs_n=0, count == WIDTH: overrun. Ignore sdi, latch an internal overrun flag, and hold count at WIDTH.
- RX, cs_n=1: go to DONE and evaluate the frame in the same edge. Outputs register on this edge, so pulses are visible for the following sck period.
  - Good frame (count == WIDTH, no overrun): gain_o = min(shift, MAX_CODE); gain_valid_o = 1; update_o pulses; clamp_o pulses if shift > MAX_CODE.
  - Bad frame (short, or overrun): gain_o and gain_valid_o unchanged; frame_err_o pulses; err_count_o increments, saturating at all-ones.
- DONE: clear the pulses, count and overrun flag, then return to IDLE.
  - If cs_n=0 already in DONE, treat the edge as the first bit of a new frame and go directly to RX. No bit is dropped for back-to-back frames.
- Latency from the last data bit to update_o: 1 sck cycle, i.e. the first rising edge seeing cs_n=1.
- With the initiator's timing, the earliest next cs_n fall is after this commit edge, so no commit is ever lost.
- sdi is only sampled while cs_n=0. Its value outside frames has no effect.
- busy_o = (state == RX).
- Comparison and clamp are unsigned. err_count_o never wraps.

Decomposition:
- Shared package pga_pkg holds:
  - the state enum (IDLE, RX, DONE), declared with an explicit 2-bit base type;
  - PGA_CODE_W = 8;
  - PGA_MAX_CODE default.
- The initiator and responder both import it.
- One natural sub-module, pga_frame_shifter: shift register, bit counter and overrun flag, with inputs shift_en/clear and outputs data, count, overrun.
- The commit, clamp and error logic stays in the top.

Test Plan:
- Reset mid-frame: 3 bits sent, rst pulsed, remaining 5 bits sent, then cs_n high → frame_err_o pulses, err_count_o=1, gain_valid_o=0, gain_o=0.
- Good frame 8'hA5 (MAX_CODE=8'hFF) → on the first edge with cs_n=1: gain_o=8'hA5, update_o pulses for 1 cycle, gain_valid_o=1, clamp_o=0.
- Clamp with MAX_CODE=8'h3F, send 8'h80 → gain_o=8'h3F, update_o and clamp_o pulse together.
- Short frame (5 bits) after a good 8'h12 → gain_o stays 8'h12, frame_err_o pulses, err_count_o increments. Overrun frame (10 bits) → same error response.
- Back-to-back frames 8'h01 then 8'hFE with cs_n high for a single cycle → two update_o pulses, final gain_o=8'hFE, no error.
- ERR_CNT_W=2, five short frames → err_count_o reads 1,2,3,3,3 with no wrap.

Source files
------------

// File: rtl/pga_pkg.sv
// Shared definitions for the PGA gain-setting serial link.
// Both the initiator and the responder import this package.
package pga_pkg;

    // Width of a gain code and of one serial frame.
    localparam int PGA_CODE_W = 8;

    // Highest legal gain code unless a design overrides it.
    localparam logic [PGA_CODE_W-1:0] PGA_MAX_CODE = 8'hFF;

    // Responder frame-reception states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        DONE = 2'd2
    } pga_state_e;

endpackage : pga_pkg

// File: rtl/pga_frame_shifter.sv
// Serial-to-parallel front end of the PGA responder: MSB-first shift
// register, received-bit counter and overrun flag. Extra bits beyond
// WIDTH are ignored and only flagged, so the captured code is never
// corrupted by an overlong frame.
module pga_frame_shifter
    import pga_pkg::*;
#(
    parameter int WIDTH = PGA_CODE_W,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             sck,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             sdi,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             overrun
);

    logic             at_full;
    logic [WIDTH-1:0] shifted;

    assign at_full = (count == CNT_W'(WIDTH));
    assign shifted = {data[WIDTH-2:0], sdi};

    // Shift, count and overrun tracking; clear+shift_en starts a new frame
    // with this edge's bit as its first bit.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples the pre-edge values of its neighbours.
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            // NOTE: the data register is reset too, so a frame cut short by
            // reset never exposes stale bits from before reset.
            data    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else if (clear) begin
            overrun <= 1'b0;
            if (shift_en) begin
                data  <= shifted;
                count <= CNT_W'(1);
            end else begin
                count <= '0;
            end
        end else if (shift_en) begin
            if (at_full) begin
                overrun <= 1'b1;
            end else begin
                data  <= shifted;
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule : pga_frame_shifter

// File: rtl/pga_responder.sv
// Device-side responder of the PGA gain-setting serial link. Receives
// MSB-first frames while cs_n is low, checks that exactly WIDTH bits
// arrived, clamps the code to MAX_CODE and holds the committed gain.
// Commit/error strobes are registered on the first rising sck that sees
// cs_n high, so they are visible for the following sck period.
module pga_responder
    import pga_pkg::*;
#(
    parameter int               WIDTH     = PGA_CODE_W,
    parameter logic [WIDTH-1:0] MAX_CODE  = WIDTH'(PGA_MAX_CODE),
    parameter int               ERR_CNT_W = 8
) (
    input  logic                 sck,
    input  logic                 rst,
    input  logic                 cs_n,
    input  logic                 sdi,
    output logic [WIDTH-1:0]     gain_o,
    output logic                 gain_valid_o,
    output logic                 update_o,
    output logic                 clamp_o,
    output logic                 frame_err_o,
    output logic [ERR_CNT_W-1:0] err_count_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    pga_state_e       state_q;
    pga_state_e       state_d;
    logic             shift_en;
    logic             clear;
    logic             commit;
    logic             reject;
    logic [WIDTH-1:0] shift_data;
    logic [CNT_W-1:0] bit_count;
    logic             overrun;
    logic             frame_ok;
    logic             over_max;
    logic [WIDTH-1:0] code_clamped;

    pga_frame_shifter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shifter (
        .sck      (sck),
        .rst      (rst),
        .shift_en (shift_en),
        .clear    (clear),
        .sdi      (sdi),
        .data     (shift_data),
        .count    (bit_count),
        .overrun  (overrun)
    );

    // A frame is good only if exactly WIDTH bits arrived with no extras.
    assign frame_ok     = (bit_count == CNT_W'(WIDTH)) && !overrun;
    assign over_max     = (shift_data > MAX_CODE);
    assign code_clamped = over_max ? MAX_CODE : shift_data;
    assign busy_o       = (state_q == RX);

    // State register.
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and shifter control; commit/reject fire on the RX exit edge.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d  = state_q;
        shift_en = 1'b0;
        clear    = 1'b0;
        commit   = 1'b0;
        reject   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cs_n) begin
                    shift_en = 1'b1;
                    state_d  = RX;
                end
            end
            RX: begin
                if (cs_n) begin
                    state_d = DONE;
                    commit  = frame_ok;
                    reject  = !frame_ok;
                end else begin
                    shift_en = 1'b1;
                end
            end
            DONE: begin
                // A back-to-back frame starts on this edge; its first bit is kept.
                clear = 1'b1;
                if (!cs_n) begin
                    shift_en = 1'b1;
                    state_d  = RX;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Committed gain, single-cycle strobes and saturating error counter.
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            gain_o       <= '0;
            gain_valid_o <= 1'b0;
            update_o     <= 1'b0;
            clamp_o      <= 1'b0;
            frame_err_o  <= 1'b0;
            err_count_o  <= '0;
        end else begin
            update_o    <= commit;
            clamp_o     <= commit && over_max;
            frame_err_o <= reject;
            if (commit) begin
                gain_o       <= code_clamped;
                gain_valid_o <= 1'b1;
            end
            if (reject && (err_count_o != {ERR_CNT_W{1'b1}})) begin
                err_count_o <= err_count_o + ERR_CNT_W'(1);
            end
        end
    end

endmodule : pga_responder
